ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding logic directly upstream of the 16-bit ALU.
- Captures decoded operands and control from the decode stage and resolves data hazards from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a bubble.
- Drives the ALU's a, b and 3-bit function select, plus the control that travels on to the EX/MEM register.

---
 rtl/ex_operand_stage_if.sv | 57 +++++
 rtl/ex_operand_stage.sv | 136 +++++++++++++
 tb/tb_ex_operand_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Bus bundle between decode, the EX operand stage and the downstream EX/MEM and MEM/WB ports.
// master: the surrounding pipeline; slave: the operand stage itself.
interface ex_operand_stage_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [AW-1:0]    id_rs_addr;
  logic [AW-1:0]    id_rt_addr;
  logic [AW-1:0]    id_rd_addr;
  logic             id_alu_src;
  logic [2:0]       id_alu_control;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             exmem_reg_write;
  logic [AW-1:0]    exmem_rd_addr;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_reg_write;
  logic [AW-1:0]    memwb_rd_addr;
  logic [WIDTH-1:0] memwb_result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic             ex_valid;
  logic [AW-1:0]    ex_rd_addr;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic [WIDTH-1:0] ex_store_data;
  logic             load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_alu_src, id_alu_control,
           id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    input  alu_a, alu_b, alu_control, ex_valid, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_alu_src, id_alu_control,
           id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    output alu_a, alu_b, alu_control, ex_valid, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, load_use_hazard
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Feeds the 16-bit ALU and the control that continues into EX/MEM.
module ex_operand_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input logic                clk,
  input logic                reset_n,
  ex_operand_stage_if.slave  io_bus
);

  logic             r_valid;
  logic [AW-1:0]    r_rs_addr;
  logic [AW-1:0]    r_rt_addr;
  logic [AW-1:0]    r_rd_addr;
  logic [WIDTH-1:0] r_rs_data;
  logic [WIDTH-1:0] r_rt_data;
  logic [WIDTH-1:0] r_imm;
  logic             r_alu_src;
  logic [2:0]       r_alu_control;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;

  logic             w_load_use;
  logic             w_bubble;
  logic             w_cap_rs_wb;
  logic             w_cap_rt_wb;
  logic             w_hold_rs_wb;
  logic             w_hold_rt_wb;
  logic [WIDTH-1:0] w_fwd_rs;
  logic [WIDTH-1:0] w_fwd_rt;

  // Load in EX whose destination is read by the instruction in decode. rt only counts when
  // it is actually consumed: as ALU b (alu_src = 0) or as store data.
  assign w_load_use = r_valid && r_mem_read && io_bus.id_valid && (r_rd_addr != '0) &&
                      ((r_rd_addr == io_bus.id_rs_addr) ||
                       ((r_rd_addr == io_bus.id_rt_addr) &&
                        (!io_bus.id_alu_src || io_bus.id_mem_write)));

  // Stall outranks the hazard; the hazard is re-evaluated once stall drops.
  assign w_bubble = io_bus.flush || (!io_bus.stall && w_load_use);

  // MEM/WB write landing in the register file this cycle is not yet visible on the read ports.
  assign w_cap_rs_wb = io_bus.memwb_reg_write && (io_bus.id_rs_addr != '0) &&
                       (io_bus.memwb_rd_addr == io_bus.id_rs_addr);
  assign w_cap_rt_wb = io_bus.memwb_reg_write && (io_bus.id_rt_addr != '0) &&
                       (io_bus.memwb_rd_addr == io_bus.id_rt_addr);

  assign w_hold_rs_wb = io_bus.memwb_reg_write && (r_rs_addr != '0) &&
                        (io_bus.memwb_rd_addr == r_rs_addr);
  assign w_hold_rt_wb = io_bus.memwb_reg_write && (r_rt_addr != '0) &&
                        (io_bus.memwb_rd_addr == r_rt_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid       <= 1'b0;
      r_rs_addr     <= '0;
      r_rt_addr     <= '0;
      r_rd_addr     <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= 3'b000;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (w_bubble) begin
      r_valid       <= 1'b0;
      r_rs_addr     <= '0;
      r_rt_addr     <= '0;
      r_rd_addr     <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= 3'b000;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (io_bus.stall) begin
      // Held operands absorb a value retiring during the stall.
      if (w_hold_rs_wb) r_rs_data <= io_bus.memwb_result;
      if (w_hold_rt_wb) r_rt_data <= io_bus.memwb_result;
    end else begin
      r_valid       <= io_bus.id_valid;
      r_rs_addr     <= io_bus.id_rs_addr;
      r_rt_addr     <= io_bus.id_rt_addr;
      r_rd_addr     <= io_bus.id_rd_addr;
      r_rs_data     <= w_cap_rs_wb ? io_bus.memwb_result : io_bus.id_rs_data;
      r_rt_data     <= w_cap_rt_wb ? io_bus.memwb_result : io_bus.id_rt_data;
      r_imm         <= io_bus.id_imm;
      r_alu_src     <= io_bus.id_alu_src;
      r_alu_control <= io_bus.id_alu_control & {3{io_bus.id_valid}};
      r_reg_write   <= io_bus.id_reg_write & io_bus.id_valid;
      r_mem_read    <= io_bus.id_mem_read & io_bus.id_valid;
      r_mem_write   <= io_bus.id_mem_write & io_bus.id_valid;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (r_rs_addr != '0) begin
      if (io_bus.exmem_reg_write && (io_bus.exmem_rd_addr == r_rs_addr)) begin
        w_fwd_rs = io_bus.exmem_result;
      end else if (io_bus.memwb_reg_write && (io_bus.memwb_rd_addr == r_rs_addr)) begin
        w_fwd_rs = io_bus.memwb_result;
      end
    end
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (r_rt_addr != '0) begin
      if (io_bus.exmem_reg_write && (io_bus.exmem_rd_addr == r_rt_addr)) begin
        w_fwd_rt = io_bus.exmem_result;
      end else if (io_bus.memwb_reg_write && (io_bus.memwb_rd_addr == r_rt_addr)) begin
        w_fwd_rt = io_bus.memwb_result;
      end
    end
  end

  assign io_bus.alu_a           = w_fwd_rs;
  assign io_bus.alu_b           = r_alu_src ? r_imm : w_fwd_rt;
  assign io_bus.ex_store_data   = w_fwd_rt;
  assign io_bus.alu_control     = r_alu_control;
  assign io_bus.ex_valid        = r_valid;
  assign io_bus.ex_rd_addr      = r_rd_addr;
  assign io_bus.ex_reg_write    = r_reg_write & r_valid;
  assign io_bus.ex_mem_read     = r_mem_read & r_valid;
  assign io_bus.ex_mem_write    = r_mem_write & r_valid;
  assign io_bus.load_use_hazard = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed bench for ex_operand_stage against a behavioural pipeline-slot model.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rs_d, rt_d, imm;
    logic        src;
    logic [2:0]  ctl;
    logic        rw, mr, mw;
  } ex_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  ex_t  m;

  ex_operand_stage_if #(.WIDTH(16), .AW(3)) bus ();

  ex_operand_stage #(.WIDTH(16), .AW(3)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic wb_hits(input logic [2:0] a);
    return (a != 3'd0) && bus.memwb_reg_write && (bus.memwb_rd_addr == a);
  endfunction

  // Value an instruction sees for register a: newest in-flight producer, else the held value.
  function automatic logic [15:0] fwd(input logic [2:0] a, input logic [15:0] held);
    if (a != 3'd0 && bus.exmem_reg_write && bus.exmem_rd_addr == a) return bus.exmem_result;
    if (wb_hits(a)) return bus.memwb_result;
    return held;
  endfunction

  function automatic logic exp_hazard(input ex_t c);
    logic uses_rt;
    uses_rt = !bus.id_alu_src || bus.id_mem_write;
    return c.valid && c.mr && bus.id_valid && c.rd != 3'd0 &&
           (c.rd == bus.id_rs_addr || (uses_rt && c.rd == bus.id_rt_addr));
  endfunction

  function automatic ex_t model_next(input ex_t c);
    ex_t n;
    n = c;
    if (bus.flush || (!bus.stall && exp_hazard(c))) begin
      n.valid = 1'b0; n.ctl = 3'd0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
    end else if (bus.stall) begin
      if (wb_hits(c.rs)) n.rs_d = bus.memwb_result;
      if (wb_hits(c.rt)) n.rt_d = bus.memwb_result;
    end else begin
      n.valid = bus.id_valid;
      n.rs = bus.id_rs_addr; n.rt = bus.id_rt_addr; n.rd = bus.id_rd_addr;
      n.rs_d = wb_hits(bus.id_rs_addr) ? bus.memwb_result : bus.id_rs_data;
      n.rt_d = wb_hits(bus.id_rt_addr) ? bus.memwb_result : bus.id_rt_data;
      n.imm = bus.id_imm; n.src = bus.id_alu_src;
      n.ctl = bus.id_valid ? bus.id_alu_control : 3'd0;
      n.rw = bus.id_reg_write && bus.id_valid;
      n.mr = bus.id_mem_read && bus.id_valid;
      n.mw = bus.id_mem_write && bus.id_valid;
    end
    return n;
  endfunction

  // Data fields are only meaningful while the slot holds a real instruction.
  task automatic check_outputs();
    check("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    check("load_use_hazard", 32'(bus.load_use_hazard), 32'(exp_hazard(m)));
    check("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    check("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    check("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
    if (m.valid) begin
      check("alu_a", 32'(bus.alu_a), 32'(fwd(m.rs, m.rs_d)));
      check("alu_b", 32'(bus.alu_b), 32'(m.src ? m.imm : fwd(m.rt, m.rt_d)));
      check("ex_store_data", 32'(bus.ex_store_data), 32'(fwd(m.rt, m.rt_d)));
      check("alu_control", 32'(bus.alu_control), 32'(m.ctl));
      check("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(m.rd));
    end
  endtask

  // Called at a negedge with inputs set: check, then advance DUT and model by one edge.
  task automatic cycle();
    ex_t n;
    #1;
    check_outputs();
    n = model_next(m);
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
    bus.id_alu_src = 0; bus.id_alu_control = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd_addr = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd_addr = 0; bus.memwb_result = 0;
  endtask

  task automatic set_id(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [15:0] rs_d, input logic [15:0] rt_d, input logic src,
                        input logic [2:0] ctl, input logic rw, input logic mr, input logic mw);
    bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_rd_addr = rd;
    bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_imm = 16'h0040;
    bus.id_alu_src = src; bus.id_alu_control = ctl;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  task automatic randomize_inputs();
    bus.stall = ($urandom_range(0, 4) == 0);
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.id_valid = ($urandom_range(0, 4) != 0);
    bus.id_rs_addr = 3'($urandom_range(0, 4));
    bus.id_rt_addr = 3'($urandom_range(0, 4));
    bus.id_rd_addr = 3'($urandom_range(0, 4));
    bus.id_rs_data = (bus.id_rs_addr == 0) ? 16'h0 : 16'($urandom);
    bus.id_rt_data = (bus.id_rt_addr == 0) ? 16'h0 : 16'($urandom);
    bus.id_imm = 16'($urandom);
    bus.id_alu_src = 1'($urandom);
    bus.id_alu_control = 3'($urandom);
    bus.id_reg_write = 1'($urandom);
    bus.id_mem_read = ($urandom_range(0, 2) == 0);
    bus.id_mem_write = ($urandom_range(0, 3) == 0);
    bus.exmem_reg_write = 1'($urandom);
    bus.exmem_rd_addr = 3'($urandom_range(0, 4));
    bus.exmem_result = 16'($urandom);
    bus.memwb_reg_write = 1'($urandom);
    bus.memwb_rd_addr = 3'($urandom_range(0, 4));
    bus.memwb_result = 16'($urandom);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    m = '0;
    clear_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    cycle();

    // EX/MEM forward with MEM/WB priority check.
    set_id(3'd2, 3'd3, 3'd6, 16'd5, 16'd7, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle();
    bus.id_valid = 0;
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 3'd2; bus.exmem_result = 16'h1234;
    #1;
    check("exmem_fwd_a", 32'(bus.alu_a), 32'h1234);
    check("exmem_fwd_b", 32'(bus.alu_b), 32'd7);
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 3'd2; bus.memwb_result = 16'hBEEF;
    #1;
    check("exmem_priority", 32'(bus.alu_a), 32'h1234);
    bus.exmem_reg_write = 0;
    #1;
    check("memwb_fwd_a", 32'(bus.alu_a), 32'hBEEF);
    @(negedge clk);
    clear_inputs();
    m = '0;
    cycle();

    // r0 is never forwarded.
    set_id(3'd0, 3'd1, 3'd1, 16'd0, 16'd9, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    cycle();
    clear_inputs();
    bus.exmem_reg_write = 1; bus.exmem_rd_addr = 3'd0; bus.exmem_result = 16'hFFFF;
    #1;
    check("r0_no_fwd", 32'(bus.alu_a), 32'h0);
    @(negedge clk);
    clear_inputs();
    m = '0;
    cycle();

    // Load-use: lw r4 in EX, add reading r4 in decode.
    set_id(3'd1, 3'd1, 3'd4, 16'd1, 16'd1, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    cycle();
    set_id(3'd4, 3'd5, 3'd6, 16'h0, 16'h0055, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    #1;
    check("load_use_set", 32'(bus.load_use_hazard), 32'd1);
    cycle();
    check("bubble_valid", 32'(bus.ex_valid), 32'd0);
    check("bubble_reg_write", 32'(bus.ex_reg_write), 32'd0);
    check("bubble_alu_control", 32'(bus.alu_control), 32'd0);
    cycle();
    bus.id_valid = 0;
    bus.memwb_reg_write = 1; bus.memwb_rd_addr = 3'd4; bus.memwb_result = 16'h4444;
    #1;
    check("load_use_fwd", 32'(bus.alu_a), 32'h4444);
    cycle();
    clear_inputs();

    // Stall with write-through of a value retiring mid-stall.
    set_id(3'd1, 3'd5, 3'd2, 16'd3, 16'h0011, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    cycle();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1;
      bus.memwb_reg_write = (i == 1);
      bus.memwb_rd_addr = 3'd5;
      bus.memwb_result = 16'h00AA;
      cycle();
    end
    clear_inputs();
    #1;
    check("stall_writethrough", 32'(bus.alu_b), 32'h00AA);
    cycle();

    // Flush beats stall.
    set_id(3'd1, 3'd2, 3'd0, 16'd1, 16'd2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
    cycle();
    clear_inputs();
    bus.flush = 1; bus.stall = 1;
    cycle();
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_mem_write", 32'(bus.ex_mem_write), 32'd0);
    clear_inputs();

    for (int i = 0; i < 500; i++) begin
      randomize_inputs();
      cycle();
    end

    // Asynchronous reset mid-cycle with a live instruction in the stage.
    clear_inputs();
    set_id(3'd3, 3'd4, 3'd5, 16'h1111, 16'h2222, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0);
    cycle();
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_alu_control", 32'(bus.alu_control), 32'd0);
    check("rst_store_data", 32'(bus.ex_store_data), 32'd0);
    check("rst_hazard", 32'(bus.load_use_hazard), 32'd0);
    @(negedge clk);
    reset_n = 1;
    m = '0;
    clear_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
